// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with wrap or saturate behaviour,
// sync clear, parallel load and registered overflow/underflow pulses.
module updown_counter_param #(
    parameter int WIDTH    = 3,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int STEP     = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             ovf,
    output logic             udf,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MAX_VAL + 1);
    localparam logic [WIDTH:0]   UP_LIM = MAX_W - STEP_W;
    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   ld_ext;
    logic [WIDTH-1:0] q_nxt;
    logic             ovf_nxt;
    logic             udf_nxt;

    assign q_ext  = {1'b0, q};
    assign ld_ext = {1'b0, load_val};

    // All compares and wrap sums are done one bit wider so q+STEP cannot alias.
    always_comb begin
        q_nxt   = q;
        ovf_nxt = 1'b0;
        udf_nxt = 1'b0;
        if (clr) begin
            q_nxt = '0;
        end else if (load) begin
            q_nxt = (ld_ext > MAX_W) ? MAX_Q : load_val;
        end else if (en) begin
            if (up) begin
                if (q_ext <= UP_LIM) begin
                    q_nxt = WIDTH'(q_ext + STEP_W);
                end else begin
                    q_nxt   = SATURATE ? MAX_Q : WIDTH'(q_ext + STEP_W - MOD_W);
                    ovf_nxt = 1'b1;
                end
            end else begin
                if (q_ext >= STEP_W) begin
                    q_nxt = WIDTH'(q_ext - STEP_W);
                end else begin
                    q_nxt   = SATURATE ? '0 : WIDTH'(q_ext + MOD_W - STEP_W);
                    udf_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q   <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            q   <= q_nxt;
            ovf <= ovf_nxt;
            udf <= udf_nxt;
        end
    end

    assign at_max  = (q == MAX_Q);
    assign at_zero = (q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three parameterisations share one stimulus
// stream and are each checked against an integer reference model.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr, load, en, up;
    logic [3:0] load_val;

    logic [2:0] q0;
    logic [3:0] q1;
    logic [2:0] q2;
    logic       ovf [3];
    logic       udf [3];
    logic       amax [3];
    logic       azero [3];

    int tests  = 0;
    int failed = 0;

    // model state and per-instance parameters
    int mq [3];
    int mo [3];
    int mu [3];
    int mx [3] = '{7, 9, 5};
    int st [3] = '{1, 3, 1};
    int sa [3] = '{0, 0, 1};
    int wd [3] = '{3, 4, 3};

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(3)) d0 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[2:0]),
        .en(en), .up(up), .q(q0), .ovf(ovf[0]), .udf(udf[0]),
        .at_max(amax[0]), .at_zero(azero[0]));

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(1'b0)) d1 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(q1), .ovf(ovf[1]), .udf(udf[1]),
        .at_max(amax[1]), .at_zero(azero[1]));

    updown_counter_param #(.WIDTH(3), .MAX_VAL(5), .STEP(1), .SATURATE(1'b1)) d2 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[2:0]),
        .en(en), .up(up), .q(q2), .ovf(ovf[2]), .udf(udf[2]),
        .at_max(amax[2]), .at_zero(azero[2]));

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i] = 0; mo[i] = 0; mu[i] = 0;
        end
    endfunction

    function automatic void model_step();
        int lv;
        if (rst !== 1'b1) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            mo[i] = 0; mu[i] = 0;
            if (clr) begin
                mq[i] = 0;
            end else if (load) begin
                lv = int'(load_val) % (1 << wd[i]);
                mq[i] = (lv > mx[i]) ? mx[i] : lv;
            end else if (en) begin
                if (up) begin
                    if (mq[i] + st[i] <= mx[i]) mq[i] = mq[i] + st[i];
                    else begin
                        mq[i] = sa[i] ? mx[i] : (mq[i] + st[i]) % (mx[i] + 1);
                        mo[i] = 1;
                    end
                end else begin
                    if (mq[i] >= st[i]) mq[i] = mq[i] - st[i];
                    else begin
                        mq[i] = sa[i] ? 0 : mq[i] + (mx[i] + 1) - st[i];
                        mu[i] = 1;
                    end
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] dq [3];
        dq[0] = {29'b0, q0};
        dq[1] = {28'b0, q1};
        dq[2] = {29'b0, q2};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.q[%0d]", tag, i), dq[i], 32'(mq[i]));
            chk($sformatf("%s.ovf[%0d]", tag, i), {31'b0, ovf[i]}, 32'(mo[i]));
            chk($sformatf("%s.udf[%0d]", tag, i), {31'b0, udf[i]}, 32'(mu[i]));
            chk($sformatf("%s.at_max[%0d]", tag, i), {31'b0, amax[i]}, 32'(mq[i] == mx[i]));
            chk($sformatf("%s.at_zero[%0d]", tag, i), {31'b0, azero[i]}, 32'(mq[i] == 0));
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic c, input logic l, input logic [3:0] v,
                         input logic e, input logic u);
        clr = c; load = l; load_val = v; en = e; up = u;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        cycle("reset");
        cycle("reset_hold");
        rst = 1'b1;
        #1 check_all("reset_release");

        // wrap up on defaults: 6 -> 7, 0 (ovf), 1
        drive(0, 1, 6, 0, 0); cycle("load6");
        drive(0, 0, 0, 1, 1);
        cycle("wrap_up1"); chk("d0_q_7", {29'b0, q0}, 7);
        cycle("wrap_up2"); chk("d0_q_0", {29'b0, q0}, 0); chk("d0_ovf", {31'b0, ovf[0]}, 1);
        cycle("wrap_up3"); chk("d0_q_1", {29'b0, q0}, 1); chk("d0_ovf_clr", {31'b0, ovf[0]}, 0);

        // wrap down, MAX 9 STEP 3: 1 -> 8 (udf), 5
        drive(0, 1, 1, 0, 0); cycle("load1");
        drive(0, 0, 0, 1, 0);
        cycle("wrap_dn1"); chk("d1_q_8", {28'b0, q1}, 8); chk("d1_udf", {31'b0, udf[1]}, 1);
        cycle("wrap_dn2"); chk("d1_q_5", {28'b0, q1}, 5);

        // saturate at MAX 5, then down from 0
        drive(0, 1, 4, 0, 0); cycle("load4");
        drive(0, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) cycle("sat_up");
        chk("d2_q_5", {29'b0, q2}, 5); chk("d2_ovf_held", {31'b0, ovf[2]}, 1);
        drive(1, 0, 0, 0, 0); cycle("clr");
        drive(0, 0, 0, 1, 0); cycle("sat_dn");
        chk("d2_udf", {31'b0, udf[2]}, 1);

        // priority
        drive(1, 1, 7, 1, 1); cycle("prio_clr");
        drive(0, 1, 3, 1, 1); cycle("prio_load");
        chk("d0_load_no_step", {29'b0, q0}, 3);

        // load clamp then hold
        drive(0, 1, 7, 0, 0); cycle("clamp");
        chk("d2_clamp", {29'b0, q2}, 5);
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle("hold");

        // async reset mid-count
        drive(0, 1, 5, 0, 0); cycle("load5");
        drive(0, 0, 0, 1, 1);
        #3 rst = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        en = 1'bx; up = 1'bx;
        cycle("x_in_reset");
        #2 rst = 1'b1;
        clr = 1'b1;
        cycle("x_with_clr");

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 16) == 0, ($urandom % 8) == 0, 4'($urandom),
                  ($urandom % 4) != 0, 1'($urandom));
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
